// File: rtl/sldu_ring_port_if.sv
// Handshake bundle between the SLDU ring endpoint and its surroundings:
// command, local tx/rx element streams and the link to the cluster ring router.
interface sldu_ring_port_if #(
    parameter int unsigned CntWidth  = 16,
    parameter int unsigned DataWidth = 64
);
    logic                 flush_i;
    logic                 cmd_valid_i;
    logic                 cmd_ready_o;
    logic                 cmd_dir_i;
    logic                 cmd_bypass_i;
    logic [CntWidth-1:0]  cmd_tx_len_i;
    logic [CntWidth-1:0]  cmd_rx_len_i;
    logic [DataWidth-1:0] tx_data_i;
    logic                 tx_valid_i;
    logic                 tx_ready_o;
    logic [DataWidth-1:0] rx_data_o;
    logic                 rx_valid_o;
    logic                 rx_ready_i;
    logic                 ring_conf_valid_o;
    logic                 ring_dir_o;
    logic                 ring_bypass_o;
    logic [DataWidth-1:0] ring_data_o;
    logic                 ring_valid_o;
    logic                 ring_ready_i;
    logic [DataWidth-1:0] ring_data_i;
    logic                 ring_valid_i;
    logic                 ring_ready_o;
    logic                 done_o;

    // master: the ring port itself; slave: SLDU datapath plus router
    modport master (
        input  flush_i, cmd_valid_i, cmd_dir_i, cmd_bypass_i, cmd_tx_len_i, cmd_rx_len_i,
        input  tx_data_i, tx_valid_i, rx_ready_i, ring_ready_i, ring_data_i, ring_valid_i,
        output cmd_ready_o, tx_ready_o, rx_data_o, rx_valid_o, ring_conf_valid_o,
        output ring_dir_o, ring_bypass_o, ring_data_o, ring_valid_o, ring_ready_o, done_o
    );

    modport slave (
        output flush_i, cmd_valid_i, cmd_dir_i, cmd_bypass_i, cmd_tx_len_i, cmd_rx_len_i,
        output tx_data_i, tx_valid_i, rx_ready_i, ring_ready_i, ring_data_i, ring_valid_i,
        input  cmd_ready_o, tx_ready_o, rx_data_o, rx_valid_o, ring_conf_valid_o,
        input  ring_dir_o, ring_bypass_o, ring_data_o, ring_valid_o, ring_ready_o, done_o
    );
endinterface

// File: rtl/sldu_ring_port.sv
// SLDU-side endpoint of the inter-cluster ring: configures the router, streams
// TX_LEN local elements out and collects RX_LEN elements through a one-entry buffer.
module sldu_ring_port #(
    parameter int unsigned CntWidth  = 16,
    parameter int unsigned DataWidth = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    sldu_ring_port_if.master  bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CONF   = 2'd1;
    localparam logic [1:0] ACTIVE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [CntWidth-1:0] CntOne = {{(CntWidth-1){1'b0}}, 1'b1};

    logic [1:0]           state_q, state_d;
    logic                 dir_q, dir_d;
    logic                 bypass_q, bypass_d;
    logic [CntWidth-1:0]  tx_cnt_q, tx_cnt_d;
    logic [CntWidth-1:0]  rx_cnt_q, rx_cnt_d;
    logic                 rx_vld_q, rx_vld_d;
    logic [DataWidth-1:0] rx_data_q, rx_data_d;

    logic in_active;
    logic tx_open;
    logic rx_open;
    logic ring_rdy;
    logic tx_fire;
    logic rx_push;
    logic rx_pop;
    logic cmd_fire;

    assign in_active = (state_q == ACTIVE);
    assign tx_open   = in_active && (tx_cnt_q != '0);
    assign rx_open   = in_active && (rx_cnt_q != '0);
    // The buffer can take a new element when empty or when it is emptied this cycle
    assign ring_rdy  = rx_open && (!rx_vld_q || bus.rx_ready_i);
    assign tx_fire   = tx_open && bus.tx_valid_i && bus.ring_ready_i;
    assign rx_push   = ring_rdy && bus.ring_valid_i;
    assign rx_pop    = rx_vld_q && bus.rx_ready_i;
    assign cmd_fire  = (state_q == IDLE) && bus.cmd_valid_i && !bus.flush_i;

    assign bus.cmd_ready_o       = (state_q == IDLE) && !bus.flush_i;
    assign bus.ring_conf_valid_o = (state_q == CONF) && !bus.flush_i;
    assign bus.ring_dir_o        = dir_q;
    assign bus.ring_bypass_o     = bypass_q;
    assign bus.ring_valid_o      = tx_open && bus.tx_valid_i;
    assign bus.tx_ready_o        = tx_open && bus.ring_ready_i;
    assign bus.ring_data_o       = in_active ? bus.tx_data_i : '0;
    assign bus.ring_ready_o      = ring_rdy;
    assign bus.rx_valid_o        = rx_vld_q;
    assign bus.rx_data_o         = rx_data_q;
    assign bus.done_o            = (state_q == DONE);

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        bypass_d  = bypass_q;
        tx_cnt_d  = tx_cnt_q;
        rx_cnt_d  = rx_cnt_q;
        rx_vld_d  = rx_vld_q;
        rx_data_d = rx_data_q;

        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    dir_d    = bus.cmd_dir_i;
                    bypass_d = bus.cmd_bypass_i;
                    tx_cnt_d = bus.cmd_bypass_i ? '0 : bus.cmd_tx_len_i;
                    rx_cnt_d = bus.cmd_bypass_i ? '0 : bus.cmd_rx_len_i;
                    state_d  = CONF;
                end
            end
            CONF: state_d = ACTIVE;
            ACTIVE: begin
                if (tx_fire) tx_cnt_d = tx_cnt_q - CntOne;
                if (rx_push) rx_cnt_d = rx_cnt_q - CntOne;
                if ((tx_cnt_q == '0) && (rx_cnt_q == '0) && (!rx_vld_q || rx_pop)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A push in the same cycle as a pop keeps the buffer full with the new element
        if (rx_push) begin
            rx_vld_d  = 1'b1;
            rx_data_d = bus.ring_data_i;
        end else if (rx_pop) begin
            rx_vld_d  = 1'b0;
        end

        if (bus.flush_i) begin
            state_d  = IDLE;
            tx_cnt_d = '0;
            rx_cnt_d = '0;
            rx_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            dir_q     <= 1'b0;
            bypass_q  <= 1'b0;
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            rx_vld_q  <= 1'b0;
            rx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            bypass_q  <= bypass_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            rx_vld_q  <= rx_vld_d;
            rx_data_q <= rx_data_d;
        end
    end
endmodule

// File: tb/tb_sldu_ring_port.sv
// Directed and randomized transfers against a queue-based model of the ring port:
// in-order tx/rx streams, exact element counts, conf strobe, done timing, flush, reset.
module tb_sldu_ring_port;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    sldu_ring_port_if #(.CntWidth(16), .DataWidth(64)) bus ();

    sldu_ring_port #(.CntWidth(16), .DataWidth(64)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.flush_i      = 1'b0;
        bus.cmd_valid_i  = 1'b0;
        bus.cmd_dir_i    = 1'b0;
        bus.cmd_bypass_i = 1'b0;
        bus.cmd_tx_len_i = '0;
        bus.cmd_rx_len_i = '0;
        bus.tx_data_i    = '0;
        bus.tx_valid_i   = 1'b0;
        bus.rx_ready_i   = 1'b0;
        bus.ring_ready_i = 1'b0;
        bus.ring_data_i  = '0;
        bus.ring_valid_i = 1'b0;
    endtask

    function automatic bit roll(input int pct);
        return ($urandom % 100) < pct;
    endfunction

    // One complete transfer. Model: the tx side must emit txd[] in order and exactly
    // eff_tx times; the rx side accepts the first eff_rx ring elements, each shown to
    // the SLDU one cycle later, in order; done follows the cycle in which everything
    // is sent, accepted and delivered. Returns the done cycle (command cycle = 0), -1 on flush.
    task automatic xfer(input string tag, input bit dir, input bit byp, input int txlen,
                        input int rxlen, input int avail, input int base, input int vpct,
                        input int rpct, input int rxpct, input bit toggle, input int rx_hold,
                        input int flush_at, output int done_cyc);
        int eff_tx;
        int eff_rx;
        int tx_sent;
        int acc;
        int src_idx;
        int cyc;
        bit done_due;
        bit next_due;
        bit done_seen;
        bit pop;
        logic [63:0] txd[$];
        logic [63:0] src[$];
        logic [63:0] bufq[$];

        eff_tx   = byp ? 0 : txlen;
        eff_rx   = byp ? 0 : rxlen;
        tx_sent  = 0;
        acc      = 0;
        src_idx  = 0;
        done_cyc = -1;
        done_due = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < txlen; i++) txd.push_back(base >= 0 ? 64'(base + i) : {$urandom, $urandom});
        for (int i = 0; i < avail; i++) src.push_back(base >= 0 ? 64'(base + i) : {$urandom, $urandom});

        // cycle 0: command
        @(posedge clk); #1;
        bus.cmd_valid_i  = 1'b1;
        bus.cmd_dir_i    = dir;
        bus.cmd_bypass_i = byp;
        bus.cmd_tx_len_i = 16'(txlen);
        bus.cmd_rx_len_i = 16'(rxlen);
        @(negedge clk);
        chkb({tag, "_cmd_ready"}, bus.cmd_ready_o, 1'b1);
        chkb({tag, "_conf_early"}, bus.ring_conf_valid_o, 1'b0);

        // cycle 1: conf strobe, no data movement even with everything offered
        @(posedge clk); #1;
        bus.cmd_valid_i  = 1'b0;
        bus.cmd_dir_i    = ~dir;
        bus.cmd_bypass_i = ~byp;
        bus.tx_valid_i   = 1'b1;
        bus.tx_data_i    = (txd.size() > 0) ? txd[0] : 64'h0;
        bus.ring_ready_i = 1'b1;
        bus.rx_ready_i   = 1'b1;
        bus.ring_valid_i = 1'b1;
        bus.ring_data_i  = (src.size() > 0) ? src[0] : 64'h0;
        @(negedge clk);
        chkb({tag, "_conf"}, bus.ring_conf_valid_o, 1'b1);
        chkb({tag, "_conf_dir"}, bus.ring_dir_o, dir);
        chkb({tag, "_conf_bypass"}, bus.ring_bypass_o, byp);
        chkb({tag, "_conf_cmd_ready"}, bus.cmd_ready_o, 1'b0);
        chkb({tag, "_conf_tx_ready"}, bus.tx_ready_o, 1'b0);
        chkb({tag, "_conf_ring_ready"}, bus.ring_ready_o, 1'b0);
        chkb({tag, "_conf_ring_valid"}, bus.ring_valid_o, 1'b0);
        @(posedge clk); #1;

        cyc = 2;
        for (int k = 0; k < 400; k++) begin
            if (flush_at >= 0 && tx_sent >= flush_at) begin
                bus.flush_i      = 1'b1;
                bus.tx_valid_i   = 1'b0;
                bus.ring_valid_i = 1'b0;
                @(negedge clk);
                chkb({tag, "_flush_no_done"}, bus.done_o, 1'b0);
                @(posedge clk); #1;
                idle_inputs();
                @(negedge clk);
                chkb({tag, "_flush_cmd_ready"}, bus.cmd_ready_o, 1'b1);
                chkb({tag, "_flush_done"}, bus.done_o, 1'b0);
                chkb({tag, "_flush_rx_valid"}, bus.rx_valid_o, 1'b0);
                chkb({tag, "_flush_conf"}, bus.ring_conf_valid_o, 1'b0);
                @(posedge clk); #1;
                @(negedge clk);
                chkb({tag, "_flush_done_late"}, bus.done_o, 1'b0);
                return;
            end
            bus.tx_valid_i   = roll(vpct);
            bus.tx_data_i    = (tx_sent < txd.size()) ? txd[tx_sent] : {$urandom, $urandom};
            bus.ring_ready_i = toggle ? (k % 2 == 0) : roll(rpct);
            bus.rx_ready_i   = (k < rx_hold) ? 1'b0 : roll(rxpct);
            bus.ring_valid_i = (src_idx < avail) ? roll(vpct) : 1'b0;
            bus.ring_data_i  = (src_idx < avail) ? src[src_idx] : 64'h0;
            @(negedge clk);

            chkb({tag, "_done"}, bus.done_o, done_due);
            if (done_due) begin
                done_cyc  = cyc;
                done_seen = 1'b1;
                chki({tag, "_tx_count"}, tx_sent, eff_tx);
                chki({tag, "_rx_count"}, acc, eff_rx);
                chki({tag, "_rx_pending"}, bufq.size(), 0);
                @(posedge clk); #1;
                idle_inputs();
                @(negedge clk);
                chkb({tag, "_idle_cmd_ready"}, bus.cmd_ready_o, 1'b1);
                chkb({tag, "_done_once"}, bus.done_o, 1'b0);
                break;
            end
            chkb({tag, "_busy_cmd_ready"}, bus.cmd_ready_o, 1'b0);
            chkb({tag, "_rx_valid"}, bus.rx_valid_o, bufq.size() != 0);
            chkb({tag, "_ring_ready"}, bus.ring_ready_o,
                 (acc < eff_rx) && (bufq.size() == 0 || bus.rx_ready_i));
            chkb({tag, "_tx_ready"}, bus.tx_ready_o, bus.ring_ready_i && (tx_sent < eff_tx));
            chkb({tag, "_ring_valid"}, bus.ring_valid_o, bus.tx_valid_i && (tx_sent < eff_tx));
            if (bus.ring_valid_o && tx_sent < eff_tx) chk({tag, "_ring_data"}, bus.ring_data_o, txd[tx_sent]);
            pop = bus.rx_valid_o && bus.rx_ready_i;
            if (pop && bufq.size() > 0) chk({tag, "_rx_data"}, bus.rx_data_o, bufq[0]);

            next_due = (tx_sent == eff_tx) && (acc == eff_rx) && (bufq.size() == 0 || pop);
            if (bus.ring_valid_o && bus.ring_ready_i) tx_sent++;
            if (pop && bufq.size() > 0) void'(bufq.pop_front());
            if (bus.ring_valid_i && bus.ring_ready_o) begin
                bufq.push_back(bus.ring_data_i);
                acc++;
                src_idx++;
            end
            done_due = next_due;
            cyc++;
            @(posedge clk); #1;
        end
        chkb({tag, "_finished_in_budget"}, done_seen, 1'b1);
        idle_inputs();
    endtask

    initial begin
        int dc;
        int tl;
        int rl;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        idle_inputs();
        #23;
        chkb("rst_cmd_ready", bus.cmd_ready_o, 1'b1);
        chkb("rst_done", bus.done_o, 1'b0);
        chkb("rst_conf", bus.ring_conf_valid_o, 1'b0);
        chkb("rst_dir", bus.ring_dir_o, 1'b0);
        chkb("rst_bypass", bus.ring_bypass_o, 1'b0);
        chkb("rst_rx_valid", bus.rx_valid_o, 1'b0);
        chk("rst_rx_data", bus.rx_data_o, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // basic: always ready, 0x10.. both ways; done one cycle after last pop
        xfer("basic", 1'b0, 1'b0, 4, 4, 4, 'h10, 100, 100, 100, 1'b0, 0, -1, dc);
        chki("basic_done_cycle", dc, 7);

        // bypass: only forwards, done at cycle 3
        xfer("bypass", 1'b1, 1'b1, 5, 0, 0, -1, 100, 100, 100, 1'b0, 0, -1, dc);
        chki("bypass_done_cycle", dc, 3);

        // backpressure: ring_ready toggles, SLDU stalls the rx buffer for 4 cycles
        xfer("backpressure", 1'b1, 1'b0, 3, 3, 3, -1, 100, 100, 100, 1'b1, 4, -1, dc);

        // asymmetric: nothing to send, 3 offered but only 2 taken
        xfer("asym", 1'b0, 1'b0, 0, 2, 3, 'h40, 100, 100, 100, 1'b0, 0, -1, dc);
        chki("asym_done_cycle", dc, 5);

        // flush after the first tx beat, then a clean follow-up command
        xfer("flush", 1'b1, 1'b0, 4, 4, 4, -1, 100, 100, 100, 1'b0, 0, 1, dc);
        xfer("after_flush", 1'b0, 1'b0, 2, 3, 3, -1, 100, 100, 100, 1'b0, 0, -1, dc);

        for (int n = 0; n < 20; n++) begin
            tl = int'($urandom_range(0, 8));
            rl = int'($urandom_range(0, 8));
            xfer("rand", 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), tl, rl,
                 rl + int'($urandom_range(0, 2)), -1, int'($urandom_range(30, 100)),
                 int'($urandom_range(30, 100)), int'($urandom_range(30, 100)), 1'b0,
                 int'($urandom_range(0, 3)), -1, dc);
        end

        // asynchronous reset in the middle of ACTIVE with a full rx buffer
        @(posedge clk); #1;
        bus.cmd_valid_i  = 1'b1;
        bus.cmd_dir_i    = 1'b1;
        bus.cmd_tx_len_i = 16'd4;
        bus.cmd_rx_len_i = 16'd4;
        @(posedge clk); #1;
        bus.cmd_valid_i  = 1'b0;
        bus.tx_valid_i   = 1'b1;
        bus.tx_data_i    = 64'h55;
        bus.ring_ready_i = 1'b0;
        bus.ring_valid_i = 1'b1;
        bus.ring_data_i  = 64'hAB;
        bus.rx_ready_i   = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chkb("pre_rst_rx_valid", bus.rx_valid_o, 1'b1);
        chkb("pre_rst_dir", bus.ring_dir_o, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chkb("arst_cmd_ready", bus.cmd_ready_o, 1'b1);
        chkb("arst_dir", bus.ring_dir_o, 1'b0);
        chkb("arst_rx_valid", bus.rx_valid_o, 1'b0);
        chk("arst_rx_data", bus.rx_data_o, 64'h0);
        chkb("arst_ring_valid", bus.ring_valid_o, 1'b0);
        chk("arst_ring_data", bus.ring_data_o, 64'h0);
        chkb("arst_ring_ready", bus.ring_ready_o, 1'b0);
        chkb("arst_tx_ready", bus.tx_ready_o, 1'b0);
        chkb("arst_done", bus.done_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        @(negedge clk);
        chkb("post_rst_cmd_ready", bus.cmd_ready_o, 1'b1);
        xfer("post_rst", 1'b0, 1'b0, 3, 2, 2, -1, 100, 100, 100, 1'b0, 0, -1, dc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sldu_ring_port.md
Name: sldu_ring_port

Overview:
- SLDU-side endpoint of the inter-cluster ring: the counterpart to the per-cluster ring router.
- Accepts one slide/reduction transfer command, emits the router configuration pulse (dir, bypass), then does two things concurrently:
  - streams exactly TX_LEN local elements onto the ring;
  - collects exactly RX_LEN elements arriving from the ring.
- Signals completion with a one-cycle done pulse.
- Sits between the SLDU datapath and its cluster's ring router.

Parameters:
- CntWidth, 16, width of element counters (max transfer length 2^CntWidth-1).
- DataWidth, $bits(elen_t), width of one ring element.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous abort; return to IDLE
- cmd_valid_i  in  1  transfer command valid
- cmd_ready_o  out  1  command accepted (IDLE only)
- cmd_dir_i  in  1  0 = move data left (slidedown), 1 = move data right
- cmd_bypass_i  in  1  cluster only forwards; no local tx/rx
- cmd_tx_len_i  in  CntWidth  elements to send
- cmd_rx_len_i  in  CntWidth  elements to receive
- tx_data_i  in  DataWidth  local element to send
- tx_valid_i  in  1  local element valid
- tx_ready_o  out  1  local element consumed
- rx_data_o  out  DataWidth  received element to SLDU
- rx_valid_o  out  1  received element valid
- rx_ready_i  in  1  SLDU accepts received element
- ring_conf_valid_o  out  1  router configuration strobe
- ring_dir_o  out  1  router direction
- ring_bypass_o  out  1  router bypass
- ring_data_o  out  DataWidth  element to router
- ring_valid_o  out  1  element to router valid
- ring_ready_i  in  1  router accepts element
- ring_data_i  in  DataWidth  element from router
- ring_valid_i  in  1  element from router valid
- ring_ready_o  out  1  accept element from router
- done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset values:
  - state IDLE; cmd_ready_o = 1.
  - All other outputs 0: ring_dir_o, ring_bypass_o, data outputs, counters, rx buffer valid.
- FSM states: IDLE, CONF, ACTIVE, DONE.
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i: latch dir, bypass, tx_cnt = tx_len, rx_cnt = rx_len; go to CONF.
  - If bypass = 1, tx_cnt and rx_cnt are forced to 0.
- CONF:
  - ring_conf_valid_o = 1 for exactly one cycle, with ring_dir_o / ring_bypass_o = latched values.
  - No data handshakes occur in this cycle.
  - Next state is ACTIVE.
- ACTIVE, tx path (combinational pass-through):
  - ring_valid_o = tx_valid_i & (tx_cnt != 0).
  - tx_ready_o = ring_ready_i & (tx_cnt != 0).
  - ring_data_o = tx_data_i.
  - tx_cnt decrements on each ring_valid_o & ring_ready_i.
- ACTIVE, rx path (one-entry registered buffer):
  - ring_ready_o = (rx_cnt != 0) & (~rx_valid_o | rx_ready_i).
  - On ring_valid_i & ring_ready_o: load the buffer and decrement rx_cnt.
  - rx_valid_o/rx_data_o appear the cycle after ring acceptance.
  - Simultaneous pop and push is allowed, giving full throughput.
- ACTIVE -> DONE when tx_cnt == 0, rx_cnt == 0 and the rx buffer is empty (drained, or being drained this cycle).
  - Zero-length and bypass transfers therefore spend one cycle in ACTIVE, then reach DONE.
- DONE: done_o = 1 for one cycle; next state IDLE. cmd_ready_o = 0 in CONF, ACTIVE and DONE.
- Outside ACTIVE:
  - ring_valid_o, tx_ready_o and ring_ready_o are 0.
  - rx_valid_o may remain high only while the buffer still holds data.
- ring_dir_o / ring_bypass_o hold the last latched values until the next command (the router captures them on the strobe).
- Latency: command accepted at cycle 0 -> conf strobe at cycle 1 -> first tx/rx beat possible at cycle 2.
- flush_i has priority over all transitions:
  - next cycle: state IDLE, counters 0, rx buffer emptied;
  - no done_o pulse;
  - no conf strobe emitted for a flushed command.
- A tx element is never dropped: tx_ready_o is never asserted without ring_ready_i.
- Elements beyond the programmed rx count are not accepted; they stay on the ring with backpressure.
- ring_valid_o and rx_valid_o, once asserted, hold with stable data until the handshake completes (flush excepted for rx).

Test Plan:
- Basic transfer: cmd dir=0, bypass=0, tx_len=4, rx_len=4, always ready, data 0x10..0x13 in each direction.
  - Required: conf strobe at cycle 1 with dir=0.
  - Required: 4 beats on each side.
  - Required: rx_data_o sequence 0x10..0x13 in order.
  - Required: done_o one cycle after the last rx pop.
- Bypass: cmd bypass=1, dir=1, tx_len=5.
  - Required: conf strobe with bypass=1.
  - Required: no tx_ready_o / ring_ready_o assertions.
  - Required: done_o at cycle 3.
- Backpressure: tx_len=3, rx_len=3, ring_ready_i toggling 1/0, rx_ready_i low for 4 cycles.
  - Required: ring_ready_o low while the buffer is full.
  - Required: no element lost or duplicated.
  - Required: counts reach exactly 3/3.
- Asymmetric and extra data: tx_len=0, rx_len=2, with 3 elements offered by the ring.
  - Required: only 2 accepted; 3rd sees ring_ready_o=0.
  - Required: done_o after 2nd pop.
- Flush: assert flush_i mid-ACTIVE after 1 of 4 tx beats.
  - Required: IDLE next cycle with cmd_ready_o=1 and no done_o.
  - Required: a subsequent command starts cleanly with a new conf strobe.
- Reset: assert rst_ni low mid-ACTIVE.
  - Required: all outputs return to reset values immediately (asynchronously).
  - Required: cmd_ready_o=1 after release.
